// File: rtl/hazard_defs.sv
// rtl/hazard_defs.sv - shared select codes, Tuse sentinel and stage-shadow type for hazard_ctrl
package hazard_defs;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_M  = 2'd1;
  localparam logic [1:0] FWD_W  = 2'd2;
  localparam logic [1:0] FWD_E  = 2'd3;

  localparam logic [CNT_W-1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [ADDR_W-1:0] wa;
    logic              we;
    logic [CNT_W-1:0]  tnew;
  } shadow_t;
endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - compares one consumer address against one stage shadow
module hazard_match
  import hazard_defs::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  shadow_t           sh,
  output logic              match,
  output logic              ready,
  output logic [CNT_W-1:0]  tnew
);
  // $0 is hardwired, so it can never match a writer
  assign match = sh.we && (sh.wa == addr) && (addr != '0);
  assign ready = (sh.tnew == '0);
  assign tnew  = sh.tnew;
endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - E/M/W scoreboard, forwarding selects and stall; MD_BUSY_EN adds mult/div stall
module hazard_ctrl
  import hazard_defs::*;
#(
  parameter int REG_W = ADDR_W,
  parameter int T_W   = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic [T_W-1:0]   d_tuse_rs,
  input  logic [T_W-1:0]   d_tuse_rt,
  input  logic [REG_W-1:0] d_wa,
  input  logic             d_we,
  input  logic [T_W-1:0]   d_tnew,
  input  logic             d_md_use,
  input  logic             md_busy,
  output logic             stall,
  output logic [1:0]       fwd_d_rs,
  output logic [1:0]       fwd_d_rt,
  output logic [1:0]       fwd_e_rs,
  output logic [1:0]       fwd_e_rt,
  output logic [1:0]       fwd_m_rt
);
  shadow_t          e_sh, m_sh, w_sh;
  logic [REG_W-1:0] e_rs, e_rt, m_rt;
  logic [T_W-1:0]   e_tnew_dec;
  logic             md_stall;

  assign e_tnew_dec = (e_sh.tnew == '0) ? '0 : e_sh.tnew - 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_sh <= '0;
      m_sh <= '0;
      w_sh <= '0;
      e_rs <= '0;
      e_rt <= '0;
      m_rt <= '0;
    end else begin
      m_sh <= {e_sh.wa, e_sh.we, e_tnew_dec};
      w_sh <= {m_sh.wa, m_sh.we, {T_W{1'b0}}};
      m_rt <= e_rt;
      if (stall) begin
        e_sh <= '0;
        e_rs <= '0;
        e_rt <= '0;
      end else begin
        e_sh <= {d_wa, d_we, d_tnew};
        e_rs <= d_rs;
        e_rt <= d_rt;
      end
    end
  end

  // Pair index: 0-2 d_rs vs E/M/W, 3-5 d_rt vs E/M/W, 6-7 e_rs vs M/W, 8-9 e_rt vs M/W, 10 m_rt vs W
  logic [REG_W-1:0] pa [11];
  shadow_t          ps [11];
  logic [10:0]      mt, rd;
  logic [T_W-1:0]   tn [11];

  assign pa = '{d_rs, d_rs, d_rs, d_rt, d_rt, d_rt, e_rs, e_rs, e_rt, e_rt, m_rt};
  assign ps = '{e_sh, m_sh, w_sh, e_sh, m_sh, w_sh, m_sh, w_sh, m_sh, w_sh, w_sh};

  for (genvar i = 0; i < 11; i++) begin : g_match
    hazard_match u_match (
      .addr  (pa[i]),
      .sh    (ps[i]),
      .match (mt[i]),
      .ready (rd[i]),
      .tnew  (tn[i])
    );
  end

  logic unused_tn;
  assign unused_tn = ^{tn[2], tn[5], tn[6], tn[7], tn[8], tn[9], tn[10]};

`ifdef MD_BUSY_EN
  assign md_stall = d_md_use & md_busy;
`else
  assign md_stall = 1'b0;
  logic unused_md;
  assign unused_md = d_md_use ^ md_busy;
`endif

  logic stall_rs, stall_rt;
  assign stall_rs = (d_tuse_rs != TUSE_NONE) &&
                    ((mt[0] && (d_tuse_rs < tn[0])) || (mt[1] && (d_tuse_rs < tn[1])));
  assign stall_rt = (d_tuse_rt != TUSE_NONE) &&
                    ((mt[3] && (d_tuse_rt < tn[3])) || (mt[4] && (d_tuse_rt < tn[4])));
  assign stall = stall_rs | stall_rt | md_stall;

  // Nearest ready producer wins; a match whose result is not ready yet never forwards
  always_comb begin
    fwd_d_rs = FWD_RF;
    fwd_d_rt = FWD_RF;
    fwd_e_rs = FWD_RF;
    fwd_e_rt = FWD_RF;
    fwd_m_rt = FWD_RF;
    if (mt[0] && rd[0])      fwd_d_rs = FWD_E;
    else if (mt[1] && rd[1]) fwd_d_rs = FWD_M;
    else if (mt[2] && rd[2]) fwd_d_rs = FWD_W;
    if (mt[3] && rd[3])      fwd_d_rt = FWD_E;
    else if (mt[4] && rd[4]) fwd_d_rt = FWD_M;
    else if (mt[5] && rd[5]) fwd_d_rt = FWD_W;
    if (mt[6] && rd[6])      fwd_e_rs = FWD_M;
    else if (mt[7] && rd[7]) fwd_e_rs = FWD_W;
    if (mt[8] && rd[8])      fwd_e_rt = FWD_M;
    else if (mt[9] && rd[9]) fwd_e_rt = FWD_W;
    if (mt[10] && rd[10])    fwd_m_rt = FWD_W;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_we, d_md_use, md_busy;
  logic       stall;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;
  int         total = 0;
  int         bad = 0;

  hazard_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_tuse_rs (d_tuse_rs),
    .d_tuse_rt (d_tuse_rt),
    .d_wa      (d_wa),
    .d_we      (d_we),
    .d_tnew    (d_tnew),
    .d_md_use  (d_md_use),
    .md_busy   (md_busy),
    .stall     (stall),
    .fwd_d_rs  (fwd_d_rs),
    .fwd_d_rt  (fwd_d_rt),
    .fwd_e_rs  (fwd_e_rs),
    .fwd_e_rt  (fwd_e_rt),
    .fwd_m_rt  (fwd_m_rt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".stall"}, {7'd0, stall}, 8'd0);
    chk({tag, ".fwd_d_rs"}, {6'd0, fwd_d_rs}, 8'd0);
    chk({tag, ".fwd_d_rt"}, {6'd0, fwd_d_rt}, 8'd0);
    chk({tag, ".fwd_e_rs"}, {6'd0, fwd_e_rs}, 8'd0);
    chk({tag, ".fwd_e_rt"}, {6'd0, fwd_e_rt}, 8'd0);
    chk({tag, ".fwd_m_rt"}, {6'd0, fwd_m_rt}, 8'd0);
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] urs,
                       input logic [1:0] urt, input logic [4:0] wa, input logic we,
                       input logic [1:0] tn);
    d_rs = rs; d_rt = rt; d_tuse_rs = urs; d_tuse_rt = urt;
    d_wa = wa; d_we = we; d_tnew = tn;
    #1;
  endtask

  task automatic nop();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; d_md_use = 1'b0; md_busy = 1'b0;
    nop();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;

    set_d(5'd7, 5'd9, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    chk("idle.stall", {7'd0, stall}, 8'd0);
    chk("idle.fwd_d_rs", {6'd0, fwd_d_rs}, 8'd0);
    chk("idle.fwd_d_rt", {6'd0, fwd_d_rt}, 8'd0);
    tick();

    // addu $3 then subu rs=$3
    set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 1'b1, 2'd1);
    tick();
    set_d(5'd3, 5'd4, 2'd1, 2'd1, 5'd6, 1'b1, 2'd1);
    chk("alu.stall", {7'd0, stall}, 8'd0);
    chk("alu.d_rs_notready", {6'd0, fwd_d_rs}, 8'd0);
    tick();
    set_d(5'd3, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0);
    chk("alu.fwd_e_rs", {6'd0, fwd_e_rs}, 8'd1);
    chk("alu.fwd_d_rs_m", {6'd0, fwd_d_rs}, 8'd1);
    tick();
    set_d(5'd3, 5'd0, 2'd0, 2'd3, 5'd0, 1'b0, 2'd0);
    chk("alu.fwd_d_rs_w", {6'd0, fwd_d_rs}, 8'd2);
    chk("alu.stall_w", {7'd0, stall}, 8'd0);
    tick();
    nop(); repeat (3) tick();

    // lw $5 then beq rs=$5
    set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd5, 1'b1, 2'd2);
    tick();
    set_d(5'd5, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    chk("load.stall1", {7'd0, stall}, 8'd1);
    tick();
    chk("load.stall2", {7'd0, stall}, 8'd1);
    chk("load.fwd_d_rs_stale", {6'd0, fwd_d_rs}, 8'd0);
    chk("load.e_bubble", {7'd0, dut.e_sh.we}, 8'd0);
    tick();
    chk("load.stall3", {7'd0, stall}, 8'd0);
    chk("load.fwd_d_rs", {6'd0, fwd_d_rs}, 8'd2);
    chk("load.e_bubble2", {7'd0, dut.e_sh.we}, 8'd0);
    tick();
    nop(); repeat (3) tick();

    // jal then jr $31
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 1'b1, 2'd0);
    tick();
    set_d(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 1'b0, 2'd0);
    chk("jal.stall", {7'd0, stall}, 8'd0);
    chk("jal.fwd_d_rs", {6'd0, fwd_d_rs}, 8'd3);
    tick();
    nop(); repeat (3) tick();

    // writer to $0 then consumer of $0
    set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 1'b1, 2'd1);
    tick();
    set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    chk_zero("zero_e");
    tick();
    chk_zero("zero_m");
    tick();
    nop(); repeat (3) tick();

    // addu $8 then sw rt=$8: forward into E then into M
    set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd8, 1'b1, 2'd1);
    tick();
    set_d(5'd0, 5'd8, 2'd1, 2'd2, 5'd0, 1'b0, 2'd0);
    chk("store.stall", {7'd0, stall}, 8'd0);
    tick();
    nop();
    chk("store.fwd_e_rt", {6'd0, fwd_e_rt}, 8'd1);
    tick();
    chk("store.fwd_m_rt", {6'd0, fwd_m_rt}, 8'd2);
    chk("store.fwd_e_rt_bubble", {6'd0, fwd_e_rt}, 8'd0);
    tick();
    repeat (3) tick();

    // mult/div busy
    d_md_use = 1'b1; md_busy = 1'b1;
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0);
`ifdef MD_BUSY_EN
    chk("md.stall", {7'd0, stall}, 8'd1);
    tick();
    chk("md.stall_held", {7'd0, stall}, 8'd1);
    md_busy = 1'b0;
    #1;
    chk("md.release", {7'd0, stall}, 8'd0);
`else
    chk("md.ignored", {7'd0, stall}, 8'd0);
    md_busy = 1'b0;
    #1;
`endif
    d_md_use = 1'b0;
    tick();
    nop(); repeat (3) tick();

    // reset while a load-use stall is active
    set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd5, 1'b1, 2'd2);
    tick();
    set_d(5'd5, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    chk("rst_stall.pre", {7'd0, stall}, 8'd1);
    reset = 1'b1;
    tick();
    chk_zero("rst_stall.post");
    reset = 1'b0;
    tick();
    chk_zero("rst_stall.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
